// File: rtl/serial_cmp_pkg.sv
// serial_cmp_pkg: shared FSM state type and default operand width for the serial comparator.
package serial_cmp_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} serial_cmp_state_t;
    localparam int SERIAL_CMP_DEFAULT_WIDTH = 8;
endpackage

// File: rtl/serial_cmp_step.sv
// serial_cmp_step: one LSB-first compare beat; a later differing bit overrides the earlier decision.
module serial_cmp_step (
    input  logic gt,
    input  logic eq,
    input  logic a_bit,
    input  logic b_bit,
    input  logic is_sign_beat,
    input  logic signed_mode,
    output logic gt_next,
    output logic eq_next
);
    logic diff;
    always_comb begin
        diff    = a_bit ^ b_bit;
        // in two's complement the sign bit has negative weight, so a set MSB means smaller
        gt_next = diff ? ((is_sign_beat && signed_mode) ? ~a_bit : a_bit) : gt;
        eq_next = eq && !diff;
    end
endmodule

// File: rtl/serial_dual_mode_comparator.sv
// serial_dual_mode_comparator: bit-serial signed/unsigned A>B and A==B compare over WIDTH valid beats.
// Define SERIAL_CMP_ABORT_EN to add abort_i, which cancels a compare in progress.
module serial_dual_mode_comparator
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = SERIAL_CMP_DEFAULT_WIDTH
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
`ifdef SERIAL_CMP_ABORT_EN
    input  logic abort_i,
`endif
    input  logic signed_i,
    input  logic bit_valid_i,
    input  logic a_bit_i,
    input  logic b_bit_i,
    output logic busy_o,
    output logic done_o,
    output logic agtb_o,
    output logic aeqb_o
);
    localparam int CW = $clog2(WIDTH);

    serial_cmp_state_t state;
    logic [CW-1:0] cnt;
    logic gt, eq, mode, gt_n, eq_n, is_sign, abort;

    assign is_sign = (cnt == CW'(WIDTH - 1));
`ifdef SERIAL_CMP_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    serial_cmp_step u_step (
        .gt          (gt),
        .eq          (eq),
        .a_bit       (a_bit_i),
        .b_bit       (b_bit_i),
        .is_sign_beat(is_sign),
        .signed_mode (mode),
        .gt_next     (gt_n),
        .eq_next     (eq_n)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            agtb_o <= 1'b0;
            aeqb_o <= 1'b0;
            cnt    <= '0;
            gt     <= 1'b0;
            eq     <= 1'b1;
            mode   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        state  <= SHIFT;
                        busy_o <= 1'b1;
                        mode   <= signed_i;
                        cnt    <= '0;
                        gt     <= 1'b0;
                        eq     <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else if (bit_valid_i) begin
                        gt  <= gt_n;
                        eq  <= eq_n;
                        cnt <= cnt + 1'b1;
                        if (is_sign) begin
                            state  <= DONE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                            agtb_o <= gt_n;
                            aeqb_o <= eq_n;
                        end
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_dual_mode_comparator.sv
// tb_serial_dual_mode_comparator: directed and random compares against an arithmetic reference.
module tb_serial_dual_mode_comparator;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic start_i = 1'b0;
    logic abort_i = 1'b0;
    logic signed_i = 1'b0;
    logic bit_valid_i = 1'b0;
    logic a_bit_i = 1'b0;
    logic b_bit_i = 1'b0;
    logic busy_o, done_o, agtb_o, aeqb_o;
    int n_checks = 0;
    int n_fail = 0;
    logic prev_gt = 1'b0;
    logic prev_eq = 1'b0;

    serial_dual_mode_comparator #(.WIDTH(8)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
`ifdef SERIAL_CMP_ABORT_EN
        .abort_i    (abort_i),
`endif
        .signed_i   (signed_i),
        .bit_valid_i(bit_valid_i),
        .a_bit_i    (a_bit_i),
        .b_bit_i    (b_bit_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .agtb_o     (agtb_o),
        .aeqb_o     (aeqb_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic ref_gt(input logic [7:0] a, input logic [7:0] b, input logic sgn);
        return sgn ? ($signed(a) > $signed(b)) : (a > b);
    endfunction

    task automatic run_cmp(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                           input int max_gap, input bit poke_start);
        logic eg, ee;
        int g;
        eg = ref_gt(a, b, sgn);
        ee = (a == b);
        start_i = 1'b1;
        signed_i = sgn;
        bit_valid_i = 1'b1;
        a_bit_i = 1'b1;
        b_bit_i = 1'b0;
        tick();
        start_i = 1'b0;
        signed_i = ~sgn;
        bit_valid_i = 1'b0;
        chk("busy_after_start", busy_o, 1'b1);
        chk("agtb_held_on_start", agtb_o, prev_gt);
        chk("aeqb_held_on_start", aeqb_o, prev_eq);
        for (int i = 0; i < 8; i++) begin
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (g) begin
                bit_valid_i = 1'b0;
                tick();
                chk("done_in_gap", done_o, 1'b0);
            end
            bit_valid_i = 1'b1;
            a_bit_i = a[i];
            b_bit_i = b[i];
            start_i = poke_start && (i == 4);
            tick();
            start_i = 1'b0;
            bit_valid_i = 1'b0;
            if (i < 7) begin
                chk("busy_mid", busy_o, 1'b1);
                chk("done_early", done_o, 1'b0);
            end else begin
                chk("done_pulse", done_o, 1'b1);
                chk("busy_at_done", busy_o, 1'b0);
                chk("agtb", agtb_o, eg);
                chk("aeqb", aeqb_o, ee);
            end
        end
        tick();
        chk("done_one_cycle", done_o, 1'b0);
        chk("busy_idle", busy_o, 1'b0);
        chk("agtb_persist", agtb_o, eg);
        chk("aeqb_persist", aeqb_o, ee);
        prev_gt = eg;
        prev_eq = ee;
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic rs;
        tick();
        tick();
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_agtb", agtb_o, 1'b0);
        chk("rst_aeqb", aeqb_o, 1'b0);
        rst_i = 1'b0;
        tick();

        run_cmp(8'h0F, 8'hFF, 1'b1, 0, 1'b0);
        run_cmp(8'h0F, 8'hFF, 1'b0, 0, 1'b0);
        run_cmp(8'h80, 8'h80, 1'b1, 0, 1'b0);
        run_cmp(8'h80, 8'h7F, 1'b1, 0, 1'b0);
        run_cmp(8'h05, 8'h03, 1'b0, 3, 1'b0);
        run_cmp(8'h05, 8'h03, 1'b0, 0, 1'b1);

        // reset partway through a compare discards everything, including the prior result
        start_i = 1'b1;
        signed_i = 1'b0;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit_valid_i = 1'b1;
            a_bit_i = 1'b1;
            b_bit_i = 1'b0;
            tick();
        end
        bit_valid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_done", done_o, 1'b0);
        chk("midrst_agtb", agtb_o, 1'b0);
        chk("midrst_aeqb", aeqb_o, 1'b0);
        tick();
        rst_i = 1'b0;
        prev_gt = 1'b0;
        prev_eq = 1'b0;
        tick();
        run_cmp(8'h01, 8'h00, 1'b0, 0, 1'b0);

`ifdef SERIAL_CMP_ABORT_EN
        start_i = 1'b1;
        signed_i = 1'b0;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid_i = 1'b1;
            a_bit_i = 1'b0;
            b_bit_i = 1'b1;
            tick();
        end
        abort_i = 1'b1;
        bit_valid_i = 1'b1;
        tick();
        abort_i = 1'b0;
        bit_valid_i = 1'b0;
        chk("abort_busy", busy_o, 1'b0);
        chk("abort_done", done_o, 1'b0);
        chk("abort_agtb", agtb_o, 1'b1);
        tick();
        chk("abort_no_late_done", done_o, 1'b0);
        chk("abort_agtb_hold", agtb_o, 1'b1);
`endif

        for (int k = 0; k < 16; k++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(3, 0) == 0) ? ra : 8'($urandom);
            rs = 1'($urandom);
            run_cmp(ra, rb, rs, 2, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
